// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router sync controller: port count, address codes,
// and default timeout sizing.
package router_pkg;

  localparam int NUM_PORTS          = 3;
  localparam int DEF_TIMEOUT_CYCLES = 30;
  localparam int DEF_CNT_W          = 5;

  typedef enum logic [1:0] {
    ADDR_P0      = 2'b00,
    ADDR_P1      = 2'b01,
    ADDR_P2      = 2'b10,
    ADDR_INVALID = 2'b11
  } addr_e;

  function automatic logic addr_valid(input logic [1:0] addr);
    return int'(addr) < NUM_PORTS;
  endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port stall counter: fires a single-cycle soft_reset after TIMEOUT_CYCLES
// consecutive stalled cycles.
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_stall,
  output logic o_soft_reset
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;

  // The pulse cycle itself always clears the count, so back-to-back stalls
  // re-arm from zero after each pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_soft_reset || !i_stall) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_soft_reset <= 1'b0;
    end
  end

  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync_ctrl.sv
// Glue between the router FSM and its three output FIFOs: address latch, write
// steering, full-flag mux, valid outputs and per-port read timeouts.
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_detect_add,
  input  logic [1:0]           i_data_in,
  input  logic                 i_write_enb_reg,
  input  logic [NUM_PORTS-1:0] i_fifo_full_in,
  input  logic [NUM_PORTS-1:0] i_fifo_empty,
  input  logic [NUM_PORTS-1:0] i_read_enb,
  output logic [NUM_PORTS-1:0] o_write_enb,
  output logic                 o_fifo_full,
  output logic [NUM_PORTS-1:0] o_vld_out,
  output logic [NUM_PORTS-1:0] o_soft_reset,
  output logic                 o_addr_err
);

  addr_e                r_addr;
  logic                 r_addr_err;
  logic [NUM_PORTS-1:0] w_stall;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr     <= ADDR_P0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= i_detect_add && !addr_valid(i_data_in);
      if (i_detect_add) begin
        r_addr <= addr_e'(i_data_in);
      end
    end
  end

  // An invalid latched address drops writes and masks full so the FSM cannot stall on it.
  always_comb begin
    o_write_enb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_write_enb[i] = i_write_enb_reg && (int'(r_addr) == i);
    end
    o_fifo_full = addr_valid(r_addr) ? i_fifo_full_in[r_addr] : 1'b0;
  end

  assign o_vld_out  = ~i_fifo_empty;
  assign w_stall    = o_vld_out & ~i_read_enb;
  assign o_addr_err = r_addr_err;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    router_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ctr (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_stall      (w_stall[gi]),
      .o_soft_reset (o_soft_reset[gi])
    );
  end

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Directed bench for router_sync_ctrl: steering, full mux, addr_err and
// per-port timeout behaviour with hand-computed expectations.
module tb_router_sync_ctrl;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_detect_add;
  logic [1:0] i_data_in;
  logic       i_write_enb_reg;
  logic [2:0] i_fifo_full_in;
  logic [2:0] i_fifo_empty;
  logic [2:0] i_read_enb;
  logic [2:0] o_write_enb;
  logic       o_fifo_full;
  logic [2:0] o_vld_out;
  logic [2:0] o_soft_reset;
  logic       o_addr_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 i_clock = ~i_clock;

  router_sync_ctrl dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_detect_add    (i_detect_add),
    .i_data_in       (i_data_in),
    .i_write_enb_reg (i_write_enb_reg),
    .i_fifo_full_in  (i_fifo_full_in),
    .i_fifo_empty    (i_fifo_empty),
    .i_read_enb      (i_read_enb),
    .o_write_enb     (o_write_enb),
    .o_fifo_full     (o_fifo_full),
    .o_vld_out       (o_vld_out),
    .o_soft_reset    (o_soft_reset),
    .o_addr_err      (o_addr_err)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_detect_add = 1'b0; i_data_in = 2'b00; i_write_enb_reg = 1'b0;
    i_fifo_full_in = 3'b001; i_fifo_empty = 3'b111; i_read_enb = 3'b000;
    #1;
    check_val("rst_soft_reset", 32'(o_soft_reset), 0);
    check_val("rst_addr_err", 32'(o_addr_err), 0);
    check_val("rst_write_enb", 32'(o_write_enb), 0);
    check_val("rst_vld_out", 32'(o_vld_out), 0);
    check_val("rst_fifo_full_p0", 32'(o_fifo_full), 1);
    tick(); tick();
    i_reset = 1'b0;
    i_fifo_full_in = 3'b000;

    // capture-cycle writes use the old address (0)
    i_detect_add = 1'b1; i_data_in = 2'b01; i_write_enb_reg = 1'b1;
    #1 check_val("capture_old_addr", 32'(o_write_enb), 32'b001);
    tick();
    i_detect_add = 1'b0; i_write_enb_reg = 1'b0;
    check_val("p1_addr_err", 32'(o_addr_err), 0);

    // steering to port 1 for 4 cycles, full follows port 1 only
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ff_pat [4];
      logic       ff_exp [4];
      ff_pat = '{3'b101, 3'b010, 3'b111, 3'b000};
      ff_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
      i_write_enb_reg = 1'b1;
      i_fifo_full_in  = ff_pat[k];
      #1;
      check_val($sformatf("p1_write_enb_%0d", k), 32'(o_write_enb), 32'b010);
      check_val($sformatf("p1_fifo_full_%0d", k), 32'(o_fifo_full), 32'(ff_exp[k]));
      tick();
    end
    i_write_enb_reg = 1'b0;
    #1 check_val("p1_write_idle", 32'(o_write_enb), 0);

    // invalid address
    i_detect_add = 1'b1; i_data_in = 2'b11;
    tick();
    i_detect_add = 1'b0; i_data_in = 2'b00;
    check_val("inv_addr_err_hi", 32'(o_addr_err), 1);
    tick();
    check_val("inv_addr_err_lo", 32'(o_addr_err), 0);
    i_write_enb_reg = 1'b1; i_fifo_full_in = 3'b111;
    #1;
    check_val("inv_write_enb", 32'(o_write_enb), 0);
    check_val("inv_fifo_full", 32'(o_fifo_full), 0);
    i_write_enb_reg = 1'b0; i_fifo_full_in = 3'b000;

    // consecutive captures: last value wins
    i_detect_add = 1'b1; i_data_in = 2'b10;
    tick();
    i_data_in = 2'b00;
    tick();
    i_detect_add = 1'b0;
    check_val("last_wins_addr_err", 32'(o_addr_err), 0);
    i_write_enb_reg = 1'b1;
    #1 check_val("last_wins_write_enb", 32'(o_write_enb), 32'b001);
    i_write_enb_reg = 1'b0;

    // timeout on port 0: pulses in cycles 31 and 62 after stall start
    i_fifo_empty = 3'b110; i_read_enb = 3'b000;
    #1 check_val("t4_vld_out", 32'(o_vld_out), 32'b001);
    for (int c = 2; c <= 63; c++) begin
      tick();
      check_val($sformatf("t4_soft_reset_c%0d", c), 32'(o_soft_reset),
                (c == 31 || c == 62) ? 32'b001 : 32'b000);
    end
    i_fifo_empty = 3'b111;
    tick();

    // late read on port 2 in cycle 30
    i_fifo_empty = 3'b011;
    for (int c = 1; c <= 29; c++) begin
      tick();
      if (c == 29 || c == 1)
        check_val($sformatf("t5_soft_reset_c%0d", c + 1), 32'(o_soft_reset), 0);
    end
    check_val("t5_cnt_before", 32'(dut.g_port[2].u_ctr.r_cnt), 29);
    i_read_enb = 3'b100;
    tick();
    check_val("t5_soft_reset_after", 32'(o_soft_reset), 0);
    check_val("t5_cnt_after", 32'(dut.g_port[2].u_ctr.r_cnt), 0);
    i_read_enb = 3'b000; i_fifo_empty = 3'b111;
    tick();
    check_val("t5_no_late_pulse", 32'(o_soft_reset), 0);

    // concurrent stalls on ports 0 and 2
    i_fifo_empty = 3'b010;
    for (int c = 2; c <= 32; c++) begin
      tick();
      check_val($sformatf("t6_soft_reset_c%0d", c), 32'(o_soft_reset),
                (c == 31) ? 32'b101 : 32'b000);
    end
    i_fifo_empty = 3'b111;
    tick();

    // reset mid-count on port 1; latched address (2) must also be dropped
    i_detect_add = 1'b1; i_data_in = 2'b10;
    tick();
    i_detect_add = 1'b0; i_data_in = 2'b00;
    i_fifo_empty = 3'b101;
    for (int c = 1; c <= 17; c++) tick();
    check_val("t1_cnt_pre", 32'(dut.g_port[1].u_ctr.r_cnt), 17);
    #2 i_reset = 1'b1; i_fifo_full_in = 3'b001;
    #1;
    check_val("t1_cnt_async", 32'(dut.g_port[1].u_ctr.r_cnt), 0);
    check_val("t1_soft_reset", 32'(o_soft_reset), 0);
    check_val("t1_addr_err", 32'(o_addr_err), 0);
    check_val("t1_addr_dropped", 32'(o_fifo_full), 1);
    tick();
    i_reset = 1'b0; i_fifo_full_in = 3'b000;
    for (int c = 2; c <= 32; c++) begin
      tick();
      check_val($sformatf("t1_soft_reset_c%0d", c), 32'(o_soft_reset),
                (c == 31) ? 32'b010 : 32'b000);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
